// File: rtl/alu_pipe_n_if.sv
// Purpose : bundle of the ALU issue side (operands, opcode, tag) and result side (R, flags, tag).
// Ports   : master = issuer (drives ACT/operands/STALL, sees BUSY/results); slave = the ALU.
// Params  : W datapath width, DSTWidth tag width, SZW size-code width.
interface alu_pipe_n_if #(
    parameter int W        = 64,
    parameter int DSTWidth = 4,
    parameter int SZW      = 2
);
    logic                ACT;
    logic                BUSY;
    logic                STALL;
    logic [DSTWidth-1:0] DSTi;
    logic [W-1:0]        A;
    logic [W-1:0]        B;
    logic [W-1:0]        C;
    logic [W-1:0]        D;
    logic [SZW-1:0]      SA;
    logic [SZW-1:0]      SB;
    logic [SZW-1:0]      SC;
    logic [SZW-1:0]      SD;
    logic [3:0]          OpCODE;
    logic                CIN;
    logic [W-1:0]        R;
    logic [W/4-1:0]      COUT;
    logic [DSTWidth-1:0] DSTo;
    logic [SZW-1:0]      SR;
    logic                RDY;
    logic                OVR;
    logic                Zero;
    logic                Sign;
    logic                ILL;

    modport master (
        output ACT, STALL, DSTi, A, B, C, D, SA, SB, SC, SD, OpCODE, CIN,
        input  BUSY, R, COUT, DSTo, SR, RDY, OVR, Zero, Sign, ILL
    );

    modport slave (
        input  ACT, STALL, DSTi, A, B, C, D, SA, SB, SC, SD, OpCODE, CIN,
        output BUSY, R, COUT, DSTo, SR, RDY, OVR, Zero, Sign, ILL
    );
endinterface

// File: rtl/alu_pipe_n.sv
// Purpose : elastic two-stage integer ALU (AND/OR/XOR/ADD/SUB/FIELDCOPY/BITCOPY/ANDN) with size masking and tags.
// Latency : 2 cycles accept-to-RDY, 1 op/clk throughput.
// Backpressure: STALL holds the stage-2 result; BUSY rises combinationally when stage 1 is full and cannot drain.
// Ports   : CLK, RESET (async active-low); bus = alu_pipe_n_if.slave carrying ACT/BUSY/STALL, operands A..D,
//           size codes SA..SD, OpCODE, CIN, DSTi in; R, COUT, DSTo, SR, RDY, OVR, Zero, Sign, ILL out.
module alu_pipe_n #(
    parameter int W        = 64,
    parameter int DSTWidth = 4,
    parameter int SZW      = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    alu_pipe_n_if.slave bus
);
    localparam int LW  = $clog2(W);
    localparam int LGS = $clog2(W / 8);
    localparam int NIB = W / 4;
    localparam logic [LW:0] EIGHT = (LW + 1)'(8);
    localparam logic [LW:0] ONE   = (LW + 1)'(1);
    localparam logic [LW:0] W_L   = (LW + 1)'(W);

    // handshake
    logic w_en1, w_en2;
    logic r_v1, r_v2;

    // stage 1 combinational
    logic [SZW-1:0] w_sz_max, w_sr;
    logic [LW:0]    w_n;
    logic [LW-1:0]  w_msb;
    logic [W-1:0]   w_bx;
    logic           w_cx;
    logic [W:0]     w_sum;
    logic [W:0]     w_cv;
    logic [LW-1:0]  w_p;
    logic [LW:0]    w_l;
    logic [W-1:0]   w_lmask, w_fc, w_res;
    logic           w_ill, w_flag_en, w_ovr;
    logic [NIB-1:0] w_cout;

    // stage 1 registers
    logic [W-1:0]          r_res1;
    logic [NIB-1:0]        r_cout1;
    logic                  r_ovr1, r_ill1;
    logic [DSTWidth-1:0]   r_dst1;
    logic [SZW-1:0]        r_sr1;

    // stage 2 combinational
    logic [LW:0]   w_n2;
    logic [LW-1:0] w_msb2;
    logic [W-1:0]  w_r2;

    // stage 2 registers (drive the outputs directly)
    logic [W-1:0]        r_r;
    logic [NIB-1:0]      r_cout;
    logic [DSTWidth-1:0] r_dst;
    logic [SZW-1:0]      r_sr;
    logic                r_ovr, r_zero, r_sign, r_ill;

    assign w_en2    = ~r_v2 | ~bus.STALL;
    assign w_en1    = ~r_v1 | w_en2;
    assign bus.BUSY = ~w_en1;

    // Result size: largest operand size, clamped to the datapath width.
    always_comb begin
        w_sz_max = bus.SA;
        if (bus.SB > w_sz_max) w_sz_max = bus.SB;
        if (bus.SC > w_sz_max) w_sz_max = bus.SC;
        if (bus.SD > w_sz_max) w_sz_max = bus.SD;
        w_sr  = (int'(w_sz_max) > LGS) ? SZW'(LGS) : w_sz_max;
        w_n   = EIGHT << w_sr;
        w_msb = LW'(w_n - ONE);
    end

    // SUB reuses the adder: A + ~B + ~CIN, so CIN=1 acts as a borrow in.
    assign w_bx  = (bus.OpCODE == 4'd4) ? ~bus.B : bus.B;
    assign w_cx  = (bus.OpCODE == 4'd4) ? ~bus.CIN : bus.CIN;
    assign w_sum = {1'b0, bus.A} + {1'b0, w_bx} + {{W{1'b0}}, w_cx};
    // w_cv[k] is the carry into bit k; w_cv[W] is the carry out of the MSB.
    assign w_cv  = {w_sum[W], bus.A ^ w_bx ^ w_sum[W-1:0]};

    // FIELDCOPY: length L may equal W, so the mask is saturated rather than shifted past width.
    assign w_p     = bus.A[LW-1:0];
    assign w_l     = bus.B[LW:0];
    assign w_lmask = (w_l >= W_L) ? {W{1'b1}} : ~({W{1'b1}} << w_l);
    assign w_fc    = (bus.D & ~(w_lmask << w_p)) | ((bus.C & w_lmask) << w_p);

    always_comb begin
        w_res     = '0;
        w_ill     = 1'b0;
        w_flag_en = 1'b0;
        case (bus.OpCODE)
            4'd0:       w_res = bus.A & bus.B;
            4'd1:       w_res = bus.A | bus.B;
            4'd2:       w_res = bus.A ^ bus.B;
            4'd3, 4'd4: begin
                w_res     = w_sum[W-1:0];
                w_flag_en = 1'b1;
            end
            4'd5:       w_res = w_fc;
            4'd6:       w_res = (bus.C & ~bus.B) | (bus.A & bus.B);
            4'd7:       w_res = bus.A & ~bus.B;
            default:    w_ill = 1'b1;
        endcase
    end

    // Nibble carries are taken at full width; only the top slot tracks the operation size.
    always_comb begin
        w_cout = '0;
        w_ovr  = 1'b0;
        if (w_flag_en) begin
            for (int i = 0; i < NIB - 1; i++) begin
                w_cout[i] = w_cv[4*i+4];
            end
            w_cout[NIB-1] = w_cv[w_n];
            w_ovr = (bus.A[w_msb] == w_bx[w_msb]) && (w_sum[w_msb] != bus.A[w_msb]);
        end
    end

    // Stage 2: clear bits at and above N, derive Sign/Zero on the sized result.
    assign w_n2   = EIGHT << r_sr1;
    assign w_msb2 = LW'(w_n2 - ONE);
    assign w_r2   = r_res1 & ~({W{1'b1}} << w_n2);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_v1    <= 1'b0;
            r_res1  <= '0;
            r_cout1 <= '0;
            r_ovr1  <= 1'b0;
            r_ill1  <= 1'b0;
            r_dst1  <= '0;
            r_sr1   <= '0;
            r_v2    <= 1'b0;
            r_r     <= '0;
            r_cout  <= '0;
            r_dst   <= '0;
            r_sr    <= '0;
            r_ovr   <= 1'b0;
            r_zero  <= 1'b0;
            r_sign  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            if (w_en1) begin
                r_v1 <= bus.ACT;
                if (bus.ACT) begin
                    r_res1  <= w_res;
                    r_cout1 <= w_cout;
                    r_ovr1  <= w_ovr;
                    r_ill1  <= w_ill;
                    r_dst1  <= bus.DSTi;
                    r_sr1   <= w_sr;
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_r    <= w_r2;
                    r_cout <= r_cout1;
                    r_dst  <= r_dst1;
                    r_sr   <= r_sr1;
                    r_ovr  <= r_ovr1;
                    r_zero <= (w_r2 == '0);
                    r_sign <= r_res1[w_msb2];
                    r_ill  <= r_ill1;
                end
            end
        end
    end

    assign bus.R    = r_r;
    assign bus.COUT = r_cout;
    assign bus.DSTo = r_dst;
    assign bus.SR   = r_sr;
    assign bus.RDY  = r_v2;
    assign bus.OVR  = r_ovr;
    assign bus.Zero = r_zero;
    assign bus.Sign = r_sign;
    assign bus.ILL  = r_ill;
endmodule

// File: tb/tb_alu_pipe_n.sv
// Purpose : directed-vector bench for alu_pipe_n with a queue scoreboard and an independent result monitor.
// Latency : expects RDY two edges after acceptance.
// Backpressure: holds STALL while results are pending to check hold, BUSY and in-order delivery.
module tb_alu_pipe_n;
    localparam int W   = 64;
    localparam int DW  = 4;
    localparam int SZW = 3;

    typedef struct packed {
        logic [W-1:0]   r;
        logic [W/4-1:0] cout;
        logic [DW-1:0]  dst;
        logic [SZW-1:0] sr;
        logic           ovr;
        logic           zero;
        logic           sign;
        logic           ill;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipe_n_if #(.W(W), .DSTWidth(DW), .SZW(SZW)) bus ();

    alu_pipe_n #(.W(W), .DSTWidth(DW), .SZW(SZW)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    res_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [W-1:0] r, input logic [W/4-1:0] c, input logic [SZW-1:0] sr,
                                input logic ovr, input logic zero, input logic sign, input logic ill);
        res_t x;
        x.r = r; x.cout = c; x.dst = '0; x.sr = sr;
        x.ovr = ovr; x.zero = zero; x.sign = sign; x.ill = ill;
        return x;
    endfunction

    // Present one operation and hold it until accepted; the expected result is queued on acceptance.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [SZW-1:0] sa, input logic [SZW-1:0] sb,
                         input logic [SZW-1:0] sc, input logic [SZW-1:0] sd,
                         input logic cin, input logic [DW-1:0] tag, input res_t e);
        int k;
        @(negedge clk);
        bus.ACT = 1'b1; bus.OpCODE = op; bus.A = a; bus.B = b; bus.C = c; bus.D = d;
        bus.SA = sa; bus.SB = sb; bus.SC = sc; bus.SD = sd; bus.CIN = cin; bus.DSTi = tag;
        #1;
        k = 0;
        while (bus.BUSY === 1'b1 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (bus.BUSY !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout tag %0d: BUSY=%b, required 0", tag, bus.BUSY);
        end else begin
            e.dst = tag;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.ACT = 1'b0;
    endtask

    task automatic drain();
        int k;
        idle();
        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
        repeat (2) @(negedge clk);
        #1;
        chk("drain_rdy", bus.RDY, 0);
    endtask

    // Monitor: a result is consumed on the edge after RDY=1 with STALL=0.
    res_t got, e_m;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && bus.RDY === 1'b1 && bus.STALL === 1'b0) begin
                got = {bus.R, bus.COUT, bus.DSTo, bus.SR, bus.OVR, bus.Zero, bus.Sign, bus.ILL};
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got tag %0d R=%h, required no result", bus.DSTo, bus.R);
                end else begin
                    e_m = q.pop_front();
                    if (got !== e_m) begin
                        n_fail++;
                        $display("FAIL result tag %0d: got R=%h COUT=%h DST=%0d SR=%0d OVR=%b Z=%b S=%b ILL=%b, required R=%h COUT=%h DST=%0d SR=%0d OVR=%b Z=%b S=%b ILL=%b",
                                 e_m.dst, got.r, got.cout, got.dst, got.sr, got.ovr, got.zero, got.sign, got.ill,
                                 e_m.r, e_m.cout, e_m.dst, e_m.sr, e_m.ovr, e_m.zero, e_m.sign, e_m.ill);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.ACT = 1'b1; bus.STALL = 1'b0; bus.OpCODE = 4'd3; bus.CIN = 1'b1;
        bus.A = {$urandom, $urandom}; bus.B = {$urandom, $urandom};
        bus.C = {$urandom, $urandom}; bus.D = {$urandom, $urandom};
        bus.SA = 3'd1; bus.SB = 3'd2; bus.SC = 3'd0; bus.SD = 3'd3; bus.DSTi = 4'd9;

        // Reset holds everything at zero even with ACT asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", {bus.R, bus.COUT, bus.DSTo, bus.SR, bus.RDY, bus.OVR, bus.Zero, bus.Sign, bus.ILL}, 0);
        chk("reset_busy", bus.BUSY, 0);
        bus.ACT = 1'b0;
        rst_n = 1'b1;

        // Latency: one ACT, RDY two edges later.
        issue(4'd3, 64'h7F, 64'h1, 0, 0, 0, 0, 0, 0, 1'b0, 4'd1, mk(64'h80, 16'h0001, 0, 1, 0, 1, 0));
        @(negedge clk);
        bus.ACT = 1'b0;
        #1;
        chk("latency_edge1_rdy", bus.RDY, 0);
        @(negedge clk);
        #1;
        chk("latency_edge2_rdy", bus.RDY, 1);

        // Adder vectors.
        issue(4'd3, 64'hFF, 64'h1, 0, 0, 0, 0, 0, 0, 1'b0, 4'd2, mk(64'h0, 16'h8003, 0, 0, 1, 0, 0));
        issue(4'd4, 64'h5, 64'h7, 0, 0, 0, 0, 0, 3, 1'b0, 4'd3, mk(64'hFFFF_FFFF_FFFF_FFFE, 16'h0000, 3, 0, 0, 1, 0));
        issue(4'd3, 64'h1_FFFF, 64'h1, 0, 0, 0, 1, 0, 0, 1'b0, 4'd4, mk(64'h0, 16'h800F, 1, 0, 1, 0, 0));
        issue(4'd4, 64'hA, 64'h3, 0, 0, 0, 0, 0, 0, 1'b1, 4'd5, mk(64'h6, 16'hFFFF, 0, 0, 0, 0, 0));
        // Field and bit copies.
        issue(4'd5, 64'd8, 64'd4, 64'hA, 64'hFFFF, 3, 0, 0, 0, 1'b0, 4'd6, mk(64'hFAFF, 0, 3, 0, 0, 0, 0));
        issue(4'd5, 64'd62, 64'd8, 64'hFF, 64'h0, 3, 0, 0, 0, 1'b0, 4'd7, mk(64'hC000_0000_0000_0000, 0, 3, 0, 0, 1, 0));
        issue(4'd5, 64'd4, 64'h80, 64'hFF, 64'h1234, 3, 0, 0, 0, 1'b0, 4'd8, mk(64'h1234, 0, 3, 0, 0, 0, 0));
        issue(4'd6, 64'hF0, 64'h3C, 64'h0F, 64'h0, 0, 0, 0, 0, 1'b0, 4'd9, mk(64'h33, 0, 0, 0, 0, 0, 0));
        // Logic ops at 16-bit size.
        issue(4'd0, 64'hF0F0, 64'hFF00, 0, 0, 1, 0, 0, 0, 1'b0, 4'd10, mk(64'hF000, 0, 1, 0, 0, 1, 0));
        issue(4'd1, 64'hF0F0, 64'hFF00, 0, 0, 1, 0, 0, 0, 1'b0, 4'd11, mk(64'hFFF0, 0, 1, 0, 0, 1, 0));
        issue(4'd2, 64'hF0F0, 64'hFF00, 0, 0, 1, 0, 0, 0, 1'b0, 4'd12, mk(64'h0FF0, 0, 1, 0, 0, 0, 0));
        issue(4'd7, 64'hF0F0, 64'hFF00, 0, 0, 1, 0, 0, 0, 1'b0, 4'd13, mk(64'h00F0, 0, 1, 0, 0, 0, 0));
        // Illegal opcode, then a legal op clears ILL; masking above N; size clamp.
        issue(4'd9, 64'hFF, 64'hFF, 0, 0, 0, 0, 0, 0, 1'b0, 4'd14, mk(64'h0, 0, 0, 0, 1, 0, 1));
        issue(4'd0, 64'hFF, 64'h0F, 0, 0, 0, 0, 0, 0, 1'b0, 4'd15, mk(64'h0F, 0, 0, 0, 0, 0, 0));
        issue(4'd0, 64'hFFFF, 64'hFF00, 0, 0, 0, 0, 0, 0, 1'b0, 4'd0, mk(64'h0, 0, 0, 0, 1, 0, 0));
        issue(4'd3, 64'h1, 64'h2, 0, 0, 0, 0, 7, 0, 1'b0, 4'd1, mk(64'h3, 0, 3, 0, 0, 0, 0));
        drain();

        // Backpressure: four back-to-back ops, stall as soon as the first result shows.
        fork
            begin
                for (int t = 1; t <= 4; t++) begin
                    issue(4'd3, W'(t), 64'h10, 0, 0, 0, 0, 0, 0, 1'b0, DW'(t),
                          mk(W'(t + 16), 0, 0, 0, 0, 0, 0));
                end
            end
            begin
                int k;
                k = 0;
                while (bus.RDY !== 1'b1 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                if (bus.RDY !== 1'b1) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stall_wait_rdy: RDY=%b, required 1", bus.RDY);
                end else begin
                    bus.STALL = 1'b1;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        #1;
                        chk("stall_hold_tag", bus.DSTo, 1);
                        chk("stall_hold_r", bus.R, 64'h11);
                        chk("stall_busy", bus.BUSY, 1);
                    end
                    @(negedge clk);
                    bus.STALL = 1'b0;
                end
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
